stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Upstream timing stage for the leaderboard.
- Measures elapsed whole-time units from start/stop button presses in slow or fast mode.
- On stop, presents the final 6-bit time, the latched mode and a one-cycle commit pulse; the leaderboard ranks the result and drives the sounds and LEDs.

Parameters:
- TICK_DIV, 100000000: clk cycles per time unit (1 s at 100 MHz); must be >= 2.
- TIME_W, 6: width of the time count; saturates at 2^TIME_W-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_btn  input  1  debounced, synchronous start level.
- stop_btn  input  1  debounced, synchronous stop level.
- clear_btn  input  1  debounced, synchronous clear/abort level.
- mode_sel  input  2  01 = slow, 10 = fast; 00 and 11 are invalid.
- time_out  output  TIME_W  live count while running; final count after stop.
- stopwatch_mode  output  2  mode latched at start; feeds the leaderboard mode input.
- time_valid  output  1  one-cycle commit pulse; time_out is final while it is high.
- running  output  1  high in RUN.
- overflow  output  1  sticky; count saturated during this run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; time_out=0; stopwatch_mode=00; time_valid=0; running=0; overflow=0; prescaler=0; button history regs=0.
- Edge detect: a button event occurs in a cycle when btn=1 and the registered previous level is 0. Holding a button produces one event.
- States: IDLE, RUN, DONE.
- IDLE:
  - time_out=0.
  - start event with mode_sel in {01,10}: latch mode_sel into stopwatch_mode, prescaler=0, overflow=0, go to RUN.
  - start event with mode_sel 00/11: ignored, stay IDLE.
  - stop and clear events: ignored.
- RUN:
  - running=1; prescaler counts 0..TICK_DIV-1.
  - tick: the cycle in which prescaler==TICK_DIV-1. Prescaler wraps to 0 and time_out increments.
  - Saturation: at 2^TIME_W-1 the count holds and overflow is set.
  - First tick arrives TICK_DIV cycles after the start edge.
  - mode_sel changes during RUN are ignored; start events are ignored.
  - stop event: go to DONE; time_valid=1 for exactly the next cycle.
  - stop coinciding with a tick: the tick increment is included in the final value.
  - clear event: abort to IDLE with time_out=0, no time_valid, stopwatch_mode kept.
  - clear and stop in the same cycle: clear wins; no commit.
- DONE:
  - time_out and stopwatch_mode held; running=0; overflow held.
  - start and stop events ignored.
  - clear event: go to IDLE, time_out=0, overflow=0.
- time_valid: registered, high exactly one cycle per completed run, in the cycle after the stop edge. It never asserts from IDLE or after an abort.
- Reset mid-run: immediate return to reset values; no commit.

Optional Feature:
- Macro: STOPWATCH_AUTOSTOP_EN.
- Defined: in RUN, the tick that first brings the count to 2^TIME_W-1 also forces the transition to DONE. overflow=1 and time_valid pulses the next cycle, exactly as for a stop event. A stop event in that same cycle produces a single commit.
- Undefined: the count saturates and holds, and the run continues until stop or clear.

Test Plan (TICK_DIV=4, TIME_W=6):
- Reset, start with mode_sel=01, 5 ticks (20 cycles), then stop -> time_valid high one cycle; time_out=5; stopwatch_mode=01; running=0; overflow=0.
- Start with mode_sel=11 -> stays IDLE, running=0. Then start with mode_sel=10, switch mode_sel to 01 mid-run, stop after 3 ticks -> stopwatch_mode=10, time_out=3.
- Stop edge in the same cycle as the 7th tick -> committed time_out=7. Then clear -> time_out=0 in IDLE.
- Clear and stop in the same cycle during RUN at count 4 -> IDLE, time_out=0, no time_valid pulse.
- Run 70 ticks without stop: macro off -> time_out holds 63, overflow=1, running=1. Macro on -> DONE at the 63rd tick, single time_valid, time_out=63.
- rst_n low for 1 cycle mid-run at count 9 -> all outputs return to reset values asynchronously; no time_valid pulse.

Source files
------------

// File: rtl/stopwatch_core_if.sv
// Stopwatch bus: debounced button levels and mode select in, timing result out.
// Modports:
//   master - button/mode driver side; reads the timing result.
//   slave  - stopwatch core side; reads buttons, drives the result.
// Signals:
//   start_btn, stop_btn, clear_btn  debounced synchronous button levels
//   mode_sel[1:0]                   01 = slow, 10 = fast
//   time_out[TIME_W-1:0]            live / final elapsed count
//   stopwatch_mode[1:0]             mode latched at start
//   time_valid                      one-cycle commit pulse
//   running                         high while timing
//   overflow                        sticky saturation flag for the current run
interface stopwatch_core_if #(
  parameter int unsigned TIME_W = 6
) ();
  logic              start_btn;
  logic              stop_btn;
  logic              clear_btn;
  logic [1:0]        mode_sel;
  logic [TIME_W-1:0] time_out;
  logic [1:0]        stopwatch_mode;
  logic              time_valid;
  logic              running;
  logic              overflow;

  modport master (
    output start_btn, stop_btn, clear_btn, mode_sel,
    input  time_out, stopwatch_mode, time_valid, running, overflow
  );

  modport slave (
    input  start_btn, stop_btn, clear_btn, mode_sel,
    output time_out, stopwatch_mode, time_valid, running, overflow
  );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch timing stage feeding the leaderboard.
// Counts whole time units (TICK_DIV clk cycles each) between a start and a stop
// button press, then presents the final count, the latched mode and a
// one-cycle commit pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    stopwatch_core_if.slave (buttons/mode in, time result out)
// Optional feature:
//   STOPWATCH_AUTOSTOP_EN - when defined, the tick that first brings the count to
//   its maximum also ends the run and commits, as a stop press would.
module stopwatch_core #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned TIME_W   = 6
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_core_if.slave bus
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0]   PreLast  = PreW'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] CountMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [PreW-1:0]   pre_q;
  logic [TIME_W-1:0] count_q;
  logic [1:0]        mode_q;
  logic              valid_q;
  logic              running_q;
  logic              ovf_q;
  logic              start_q, stop_q, clear_q;

  logic start_ev, stop_ev, clear_ev;
  logic mode_ok;
  logic tick;
  logic reach_max;
  logic finish;

  always_comb begin
    start_ev  = bus.start_btn & ~start_q;
    stop_ev   = bus.stop_btn & ~stop_q;
    clear_ev  = bus.clear_btn & ~clear_q;
    mode_ok   = ^bus.mode_sel;
    tick      = (pre_q == PreLast);
    // Tick that moves the count onto its maximum value.
    reach_max = tick && (count_q == CountMax - 1'b1);
`ifdef STOPWATCH_AUTOSTOP_EN
    finish    = stop_ev | reach_max;
`else
    finish    = stop_ev;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      count_q   <= '0;
      mode_q    <= 2'b00;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      stop_q  <= bus.stop_btn;
      clear_q <= bus.clear_btn;
      valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          count_q <= '0;
          if (start_ev && mode_ok) begin
            state_q   <= StRun;
            mode_q    <= bus.mode_sel;
            pre_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b1;
          end
        end

        StRun: begin
          if (clear_ev) begin
            // Abort: clear beats a simultaneous stop, no commit.
            state_q   <= StIdle;
            count_q   <= '0;
            pre_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
          end else begin
            if (tick) begin
              pre_q <= '0;
              if (count_q != CountMax) begin
                count_q <= count_q + 1'b1;
              end
              if (reach_max) begin
                ovf_q <= 1'b1;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
            // The same-cycle tick increment above lands in the committed value.
            if (finish) begin
              state_q   <= StDone;
              valid_q   <= 1'b1;
              running_q <= 1'b0;
            end
          end
        end

        StDone: begin
          if (clear_ev) begin
            state_q <= StIdle;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end

        default: begin
          state_q   <= StIdle;
          count_q   <= '0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_out       = count_q;
  assign bus.stopwatch_mode = mode_q;
  assign bus.time_valid     = valid_q;
  assign bus.running        = running_q;
  assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned TimeW   = 6;
  localparam int unsigned MaxCnt  = (1 << TimeW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Expected commits: {stopwatch_mode, time_out}, pushed when the stop is driven.
  logic [TimeW+1:0] exp_q[$];

  stopwatch_core_if #(.TIME_W(TimeW)) bus ();

  stopwatch_core #(
    .TICK_DIV(TickDiv),
    .TIME_W  (TimeW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops one expectation per observed commit pulse.
  task automatic monitor();
    logic [TimeW+1:0] e;
    forever begin
      @(negedge clk);
      if (bus.time_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: got time=%0d mode=%b, required no pulse",
                   bus.time_out, bus.stopwatch_mode);
        end else begin
          e = exp_q.pop_front();
          if ({bus.stopwatch_mode, bus.time_out} !== e || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL commit_value: got mode=%b time=%0d running=%b, required mode=%b time=%0d running=0",
                     bus.stopwatch_mode, bus.time_out, bus.running, e[TimeW+1:TimeW],
                     e[TimeW-1:0]);
          end
        end
      end
    end
  endtask

  task automatic start_run(input logic [1:0] mode);
    step();
    bus.mode_sel  = mode;
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
  endtask

  // Stop m cycles after the start edge; expected count is whole ticks elapsed.
  task automatic stop_after(input int m, input logic [1:0] mode);
    int unsigned t;
    t = m / TickDiv;
    if (t > MaxCnt) t = MaxCnt;
    repeat (m - 1) step();
    bus.stop_btn = 1'b1;
    exp_q.push_back({mode, TimeW'(t)});
    step();
    bus.stop_btn = 1'b0;
    step();
  endtask

  task automatic do_clear();
    bus.clear_btn = 1'b1;
    step();
    bus.clear_btn = 1'b0;
    step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({bus.time_out, bus.stopwatch_mode, bus.time_valid, bus.running, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: got time=%0d mode=%b valid=%b run=%b ovf=%b, required all 0",
               bus.time_out, bus.stopwatch_mode, bus.time_valid, bus.running, bus.overflow);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    start_run(2'b01);
    checks++;
    if (bus.running !== 1'b1) begin
      errors++;
      $display("FAIL basic_running: got %b, required 1", bus.running);
    end
    stop_after(22, 2'b01);
    checks++;
    if (bus.time_out !== 6'd5 || bus.stopwatch_mode !== 2'b01 || bus.running !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.time_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got time=%0d mode=%b run=%b ovf=%b valid=%b, required 5 01 0 0 0",
               bus.time_out, bus.stopwatch_mode, bus.running, bus.overflow, bus.time_valid);
    end
    // Start and stop are ignored in DONE.
    bus.start_btn = 1'b1;
    bus.stop_btn  = 1'b1;
    step();
    bus.start_btn = 1'b0;
    bus.stop_btn  = 1'b0;
    repeat (6) step();
    checks++;
    if (bus.time_out !== 6'd5 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got time=%0d run=%b, required 5 0", bus.time_out, bus.running);
    end
    do_clear();
    checks++;
    if (bus.time_out !== 6'd0 || bus.stopwatch_mode !== 2'b01) begin
      errors++;
      $display("FAIL clear_idle: got time=%0d mode=%b, required 0 01",
               bus.time_out, bus.stopwatch_mode);
    end
  endtask

  task automatic test_mode();
    start_run(2'b11);
    repeat (6) step();
    checks++;
    if (bus.running !== 1'b0 || bus.time_out !== 6'd0 || bus.stopwatch_mode !== 2'b01) begin
      errors++;
      $display("FAIL invalid_mode: got run=%b time=%0d mode=%b, required 0 0 01",
               bus.running, bus.time_out, bus.stopwatch_mode);
    end
    start_run(2'b10);
    bus.mode_sel = 2'b01;
    stop_after(13, 2'b10);
    checks++;
    if (bus.stopwatch_mode !== 2'b10 || bus.time_out !== 6'd3) begin
      errors++;
      $display("FAIL mode_latch: got mode=%b time=%0d, required 10 3",
               bus.stopwatch_mode, bus.time_out);
    end
    do_clear();
  endtask

  task automatic test_tick_coincide();
    start_run(2'b01);
    stop_after(28, 2'b01);
    checks++;
    if (bus.time_out !== 6'd7) begin
      errors++;
      $display("FAIL stop_on_tick: got time=%0d, required 7", bus.time_out);
    end
    do_clear();
    checks++;
    if (bus.time_out !== 6'd0 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL clear_after_tick: got time=%0d run=%b, required 0 0",
               bus.time_out, bus.running);
    end
  endtask

  task automatic test_clear_stop();
    start_run(2'b10);
    repeat (16) step();
    checks++;
    if (bus.time_out !== 6'd4 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: got time=%0d run=%b, required 4 1", bus.time_out, bus.running);
    end
    bus.clear_btn = 1'b1;
    bus.stop_btn  = 1'b1;
    step();
    bus.clear_btn = 1'b0;
    bus.stop_btn  = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.time_out !== 6'd0 || bus.running !== 1'b0 || bus.stopwatch_mode !== 2'b10) begin
      errors++;
      $display("FAIL clear_wins: got time=%0d run=%b mode=%b, required 0 0 10",
               bus.time_out, bus.running, bus.stopwatch_mode);
    end
  endtask

  task automatic test_overflow();
    start_run(2'b01);
    repeat (250) step();
    checks++;
    if (bus.time_out !== 6'd62 || bus.overflow !== 1'b0 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL pre_saturate: got time=%0d ovf=%b run=%b, required 62 0 1",
               bus.time_out, bus.overflow, bus.running);
    end
`ifdef STOPWATCH_AUTOSTOP_EN
    exp_q.push_back({2'b01, TimeW'(MaxCnt)});
    repeat (30) step();
    checks++;
    if (bus.time_out !== 6'd63 || bus.overflow !== 1'b1 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL autostop: got time=%0d ovf=%b run=%b, required 63 1 0",
               bus.time_out, bus.overflow, bus.running);
    end
`else
    repeat (30) step();
    checks++;
    if (bus.time_out !== 6'd63 || bus.overflow !== 1'b1 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL saturate_hold: got time=%0d ovf=%b run=%b, required 63 1 1",
               bus.time_out, bus.overflow, bus.running);
    end
    bus.stop_btn = 1'b1;
    exp_q.push_back({2'b01, TimeW'(MaxCnt)});
    step();
    bus.stop_btn = 1'b0;
    step();
    checks++;
    if (bus.time_out !== 6'd63 || bus.overflow !== 1'b1 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL saturate_stop: got time=%0d ovf=%b run=%b, required 63 1 0",
               bus.time_out, bus.overflow, bus.running);
    end
`endif
    do_clear();
    checks++;
    if (bus.overflow !== 1'b0 || bus.time_out !== 6'd0) begin
      errors++;
      $display("FAIL clear_overflow: got ovf=%b time=%0d, required 0 0",
               bus.overflow, bus.time_out);
    end
  endtask

  task automatic test_reset_midrun();
    start_run(2'b10);
    repeat (36) step();
    checks++;
    if (bus.time_out !== 6'd9) begin
      errors++;
      $display("FAIL pre_reset: got time=%0d, required 9", bus.time_out);
    end
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.time_out, bus.stopwatch_mode, bus.time_valid, bus.running, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL async_reset: got time=%0d mode=%b valid=%b run=%b ovf=%b, required all 0",
               bus.time_out, bus.stopwatch_mode, bus.time_valid, bus.running, bus.overflow);
    end
    step();
    rst_n = 1'b1;
    repeat (8) step();
    checks++;
    if (bus.running !== 1'b0 || bus.time_out !== 6'd0 || bus.stopwatch_mode !== 2'b00) begin
      errors++;
      $display("FAIL post_reset: got run=%b time=%0d mode=%b, required 0 0 00",
               bus.running, bus.time_out, bus.stopwatch_mode);
    end
  endtask

  initial begin
    bus.start_btn = 1'b0;
    bus.stop_btn  = 1'b0;
    bus.clear_btn = 1'b0;
    bus.mode_sel  = 2'b00;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_mode();
    test_tick_coincide();
    test_clear_stop();
    test_overflow();
    test_reset_midrun();
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_commits: got %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
